// File: rtl/seg_swap_pipe_if.sv
// Handshake bundle for seg_swap_pipe; parity signals appear only
// when SEG_SWAP_PIPE_PARITY_EN is defined.
interface seg_swap_pipe_if #(
    parameter int DATA_W = 32,
    parameter int ROT_W  = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [1:0]        mode;
    logic [ROT_W-1:0]  rot;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [15:0]       xfer_count;
`ifdef SEG_SWAP_PIPE_PARITY_EN
    logic              out_parity;
    logic              parity_err_inject;

    modport master (
        output in_valid, in_data, mode, rot, out_ready,
        output parity_err_inject,
        input  in_ready, out_valid, out_data, xfer_count,
        input  out_parity
    );

    modport slave (
        input  in_valid, in_data, mode, rot, out_ready,
        input  parity_err_inject,
        output in_ready, out_valid, out_data, xfer_count,
        output out_parity
    );
`else
    modport master (
        output in_valid, in_data, mode, rot, out_ready,
        input  in_ready, out_valid, out_data, xfer_count
    );

    modport slave (
        input  in_valid, in_data, mode, rot, out_ready,
        output in_ready, out_valid, out_data, xfer_count
    );
`endif
endinterface

// File: rtl/seg_swap_pipe.sv
// Elastic segment-permutation pipeline (pass/reverse/pair-swap/rotate).
// Optional parity lane: define SEG_SWAP_PIPE_PARITY_EN.
module seg_swap_pipe #(
    parameter int DATA_W = 32,
    parameter int SEG_W  = 4,
    parameter int STAGES = 2,
    parameter int ROT_W  = ($clog2(DATA_W / SEG_W) < 1) ? 1
                         : $clog2(DATA_W / SEG_W)
) (
    input logic          clk,
    input logic          reset,
    seg_swap_pipe_if.slave bus
);
    localparam int NSEG = DATA_W / SEG_W;

    logic [DATA_W-1:0]   perm;
    logic [2*DATA_W-1:0] dbl;
    logic [ROT_W-1:0]    r;
    logic                in_fire;
    logic [STAGES-1:0]   vld;
    logic [STAGES-1:0]   adv;
    logic [DATA_W-1:0]   dat [STAGES];
    logic [15:0]         cnt;

    always_comb begin
        perm = bus.in_data;
        dbl  = {bus.in_data, bus.in_data};
        r    = ROT_W'(bus.rot % NSEG);
        unique case (1'b1)
            (bus.mode == 2'd1): begin
                for (int i = 0; i < NSEG; i++)
                    perm[i*SEG_W +: SEG_W] =
                        bus.in_data[(NSEG-1-i)*SEG_W +: SEG_W];
            end
            (bus.mode == 2'd2): begin
                for (int k = 0; k + 1 < NSEG; k += 2) begin
                    perm[k*SEG_W +: SEG_W] =
                        bus.in_data[(k+1)*SEG_W +: SEG_W];
                    perm[(k+1)*SEG_W +: SEG_W] =
                        bus.in_data[k*SEG_W +: SEG_W];
                end
            end
            (bus.mode == 2'd3): begin
                // upper half of the doubled word is the left rotation
                dbl  = dbl << (r * SEG_W);
                perm = dbl[2*DATA_W-1 -: DATA_W];
            end
            default: perm = bus.in_data;
        endcase
    end

    // a stage moves when some stage above it is empty or the sink drains
    always_comb begin
        logic go;
        go  = bus.out_ready;
        adv = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv[k] = vld[k] && go;
            go     = go || !vld[k];
        end
    end

    assign bus.in_ready   = !vld[0] || adv[0];
    assign in_fire        = bus.in_valid && bus.in_ready;
    assign bus.out_valid  = vld[STAGES-1];
    assign bus.out_data   = dat[STAGES-1];
    assign bus.xfer_count = cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld <= '0;
            cnt <= '0;
            for (int k = 0; k < STAGES; k++)
                dat[k] <= '0;
        end else begin
            if (bus.out_valid && bus.out_ready)
                cnt <= cnt + 16'd1;
            if (in_fire) begin
                vld[0] <= 1'b1;
                dat[0] <= perm;
            end else if (adv[0]) begin
                vld[0] <= 1'b0;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (adv[k-1]) begin
                    vld[k] <= 1'b1;
                    dat[k] <= dat[k-1];
                end else if (adv[k]) begin
                    vld[k] <= 1'b0;
                end
            end
        end
    end

`ifdef SEG_SWAP_PIPE_PARITY_EN
    logic [STAGES-1:0] par;

    assign bus.out_parity = par[STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            par <= '0;
        end else begin
            if (in_fire)
                par[0] <= (^perm) ^ bus.parity_err_inject;
            for (int k = 1; k < STAGES; k++)
                if (adv[k-1])
                    par[k] <= par[k-1];
        end
    end
`endif
endmodule
